ntt_addr_gen: RTL and testbench

Address and twiddle-index generator between the NTT control FSM and the butterfly datapath/coefficient RAM. It consumes the control FSM's mode and newloop pulse and emits per-butterfly read/write addresses, twiddle-ROM indices and enables. It returns crt_sig, a one-cycle layer-complete pulse, to the control FSM. It also drives sequential addresses for the IN (load) and OUT (unload) phases.

---
 rtl/ntt_pkg.sv | 23 ++
 rtl/ntt_delay_line.sv | 27 ++
 rtl/ntt_addr_gen.sv | 167 ++++++++++++++++
 tb/tb_ntt_addr_gen.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants, mode encodings and FSM state type for the NTT address generator.
package ntt_pkg;

    localparam int unsigned DEF_N      = 256;
    localparam int unsigned DEF_LOGN   = 8;
    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_BF_LAT = 4;

    // Mode encodings as driven by the control FSM's mode_out.
    localparam logic [1:0] MODE_NTT  = 2'b00;
    localparam logic [1:0] MODE_INTT = 2'b01;
    localparam logic [1:0] MODE_IN   = 2'b10;
    localparam logic [1:0] MODE_OUT  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_SEQ   = 3'd4
    } state_t;

endpackage

// File: rtl/ntt_delay_line.sv
// Clock-enabled shift register; matches write-side timing to the butterfly pipeline.
module ntt_delay_line #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe [DEPTH];

    // Shift one stage per enabled cycle; holds completely while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else if (en) begin
            pipe[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/ntt_addr_gen.sv
// Butterfly / sequential address and twiddle-index generator for the NTT datapath.
module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter int unsigned N      = DEF_N,
    parameter int unsigned LOGN   = DEF_LOGN,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned BF_LAT = DEF_BF_LAT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic                      newloop,
    output logic [ADDR_W-1:0]         rd_addr_a,
    output logic [ADDR_W-1:0]         rd_addr_b,
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         tw_idx,
    output logic [ADDR_W-1:0]         wr_addr_a,
    output logic [ADDR_W-1:0]         wr_addr_b,
    output logic                      wr_en,
    output logic [$clog2(LOGN)-1:0]   layer,
    output logic                      crt_sig,
    output logic                      busy
);

    localparam int unsigned LAYER_W = $clog2(LOGN);
    localparam int unsigned DL_W    = 1 + 2 * ADDR_W;

    localparam logic [ADDR_W-1:0]  J_ISSUE_LAST = ADDR_W'(N / 2 - 1);
    localparam logic [ADDR_W-1:0]  J_SEQ_LAST   = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0]  J_DRAIN_LAST = ADDR_W'(BF_LAT - 1);
    localparam logic [LAYER_W-1:0] LAYER_LAST   = LAYER_W'(LOGN - 1);

    state_t              state, state_d;
    logic [ADDR_W-1:0]   j, j_d;
    logic [LAYER_W-1:0]  layer_d;
    logic [1:0]          cur_mode, cur_mode_d;

    logic                is_ntt;
    logic [LAYER_W-1:0]  len_log;
    logic [ADDR_W-1:0]   len, mask, tw_base;
    logic [ADDR_W-1:0]   bf_a, bf_b, bf_tw;
    logic [DL_W-1:0]     dl_d, dl_q;

    // State, counter, layer and captured-mode registers; everything freezes while start is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            j        <= '0;
            layer    <= '0;
            cur_mode <= MODE_NTT;
        end else begin
            state    <= state_d;
            j        <= j_d;
            layer    <= layer_d;
            cur_mode <= cur_mode_d;
        end
    end

    // Next-state: pass sequencing, layer advance and layer reset on a new mode.
    always_comb begin
        state_d    = state;
        j_d        = j;
        layer_d    = layer;
        cur_mode_d = cur_mode;
        if (start) begin
            unique case (state)
                ST_IDLE: begin
                    if (mode != cur_mode) begin
                        layer_d    = '0;
                        cur_mode_d = mode;
                    end
                    if (newloop) begin
                        j_d     = '0;
                        state_d = (mode == MODE_NTT || mode == MODE_INTT) ? ST_ISSUE : ST_SEQ;
                    end
                end
                ST_ISSUE: begin
                    if (j == J_ISSUE_LAST) begin
                        j_d     = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        j_d = j + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (j == J_DRAIN_LAST) begin
                        j_d     = '0;
                        state_d = ST_DONE;
                    end else begin
                        j_d = j + ADDR_W'(1);
                    end
                end
                ST_DONE: begin
                    layer_d = (layer == LAYER_LAST) ? '0 : layer + LAYER_W'(1);
                    state_d = ST_IDLE;
                end
                ST_SEQ: begin
                    if (j == J_SEQ_LAST) begin
                        j_d     = '0;
                        state_d = ST_IDLE;
                    end else begin
                        j_d = j + ADDR_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Butterfly addressing: a inserts a zero at bit len_log of j, b sets it; grp = j >> len_log.
    always_comb begin
        is_ntt  = (cur_mode == MODE_NTT);
        len_log = is_ntt ? (LAYER_LAST - layer) : layer;
        len     = ADDR_W'(1) << len_log;
        mask    = len - ADDR_W'(1);
        bf_a    = ((j & ~mask) << 1) | (j & mask);
        bf_b    = bf_a | len;
        tw_base = is_ntt ? (ADDR_W'(1) << layer) : (ADDR_W'(1) << (LAYER_LAST - layer));
        bf_tw   = tw_base + (j >> len_log);
    end

    ntt_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (BF_LAT)
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .en  (start),
        .d   (dl_d),
        .q   (dl_q)
    );

    // Output decode: read side straight from state, write side from the delay line except IN passes.
    always_comb begin
        rd_en     = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        tw_idx    = '0;
        wr_en     = 1'b0;
        wr_addr_a = '0;
        wr_addr_b = '0;
        dl_d      = '0;
        crt_sig   = (state == ST_DONE) && start;
        busy      = (state != ST_IDLE);
        if (state == ST_ISSUE) begin
            rd_en     = start;
            rd_addr_a = bf_a;
            rd_addr_b = bf_b;
            tw_idx    = bf_tw;
            dl_d      = {start, bf_a, bf_b};
        end else if (state == ST_SEQ && cur_mode == MODE_OUT) begin
            rd_en     = start;
            rd_addr_a = j;
        end
        if (state == ST_SEQ && cur_mode == MODE_IN) begin
            wr_en     = start;
            wr_addr_a = j;
        end else begin
            wr_en     = dl_q[DL_W-1] && start;
            wr_addr_a = dl_q[2*ADDR_W-1:ADDR_W];
            wr_addr_b = dl_q[ADDR_W-1:0];
        end
    end

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Randomized bench for ntt_addr_gen against an active-cycle-indexed behavioural model.
module tb_ntt_addr_gen;
    import ntt_pkg::*;

    localparam int N      = DEF_N;
    localparam int LOGN   = DEF_LOGN;
    localparam int ADDR_W = DEF_ADDR_W;
    localparam int BF     = DEF_BF_LAT;

    logic clk = 1'b0;
    logic rst, start, newloop;
    logic [1:0] mode;
    logic [ADDR_W-1:0] rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b;
    logic rd_en, wr_en, crt_sig, busy;
    logic [2:0] layer;

    always #5 clk = ~clk;

    ntt_addr_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .newloop   (newloop),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_en     (rd_en),
        .tw_idx    (tw_idx),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .wr_en     (wr_en),
        .layer     (layer),
        .crt_sig   (crt_sig),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit armed = 1'b0;
    int t0 = 0;
    int first_wr = -1;
    int crt_cyc = -1;

    // Model state: pass in progress, index of the next active cycle within it, layer bookkeeping.
    bit         m_busy = 1'b0;
    int         m_cnt = 0;
    int         m_layer = 0;
    logic [1:0] m_op = MODE_NTT;
    logic [1:0] m_last = MODE_NTT;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_layer_op(input logic [1:0] md);
        return (md == MODE_NTT) || (md == MODE_INTT);
    endfunction

    // Textbook butterfly indexing with plain division and modulo.
    function automatic void bf_model(input logic [1:0] md, input int ly, input int j,
                                     output int a, output int b, output int tw);
        int len, base, grp, pos;
        if (md == MODE_NTT) begin
            len  = N >> (ly + 1);
            base = 1 << ly;
        end else begin
            len  = 1 << ly;
            base = N >> (ly + 1);
        end
        grp = j / len;
        pos = j % len;
        a   = 2 * grp * len + pos;
        b   = a + len;
        tw  = (base + grp) % N;
    endfunction

    // Model update: a pass is a fixed schedule over active (start-high) cycles.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_busy  <= 1'b0;
            m_cnt   <= 0;
            m_layer <= 0;
            m_last  <= MODE_NTT;
        end else if (!m_busy) begin
            if (start) begin
                if (mode != m_last) begin
                    m_layer <= 0;
                    m_last  <= mode;
                end
                if (newloop) begin
                    m_busy <= 1'b1;
                    m_cnt  <= 0;
                    m_op   <= mode;
                end
            end
        end else if (start) begin
            if (is_layer_op(m_op)) begin
                if (m_cnt == N / 2 + BF) begin
                    m_busy  <= 1'b0;
                    m_layer <= (m_layer + 1) % LOGN;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end else begin
                if (m_cnt == N - 1) m_busy <= 1'b0;
                else                m_cnt  <= m_cnt + 1;
            end
        end
    end

    // Compare process: every cycle, DUT outputs against the model's schedule.
    always @(negedge clk) begin
        bit e_rd, e_wr, e_crt;
        int jr, jw, a, b, tw;
        if (armed) begin
            e_rd = 0; e_wr = 0; e_crt = 0; jr = 0; jw = 0;
            if (m_busy && start) begin
                if (is_layer_op(m_op)) begin
                    if (m_cnt < N / 2) begin e_rd = 1; jr = m_cnt; end
                    if (m_cnt >= BF && m_cnt < N / 2 + BF) begin e_wr = 1; jw = m_cnt - BF; end
                    if (m_cnt == N / 2 + BF) e_crt = 1;
                end else if (m_op == MODE_IN) begin
                    e_wr = 1; jw = m_cnt;
                end else begin
                    e_rd = 1; jr = m_cnt;
                end
            end
            chk("rd_en", 32'(rd_en), 32'(e_rd));
            chk("wr_en", 32'(wr_en), 32'(e_wr));
            chk("crt_sig", 32'(crt_sig), 32'(e_crt));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("layer", 32'(layer), 32'(m_layer));
            if (e_rd) begin
                if (is_layer_op(m_op)) begin
                    bf_model(m_op, m_layer, jr, a, b, tw);
                    chk("rd_addr_a", 32'(rd_addr_a), 32'(a));
                    chk("rd_addr_b", 32'(rd_addr_b), 32'(b));
                    chk("tw_idx", 32'(tw_idx), 32'(tw));
                end else begin
                    chk("out_rd_addr", 32'(rd_addr_a), 32'(jr));
                end
            end
            if (e_wr) begin
                if (is_layer_op(m_op)) begin
                    bf_model(m_op, m_layer, jw, a, b, tw);
                    chk("wr_addr_a", 32'(wr_addr_a), 32'(a));
                    chk("wr_addr_b", 32'(wr_addr_b), 32'(b));
                end else begin
                    chk("in_wr_addr", 32'(wr_addr_a), 32'(jw));
                end
            end
            if (wr_en === 1'b1 && first_wr < 0) first_wr = cyc;
            if (crt_sig === 1'b1 && crt_cyc < 0) crt_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(rd_en), 0);
        chk({tag, "_wr_en"}, 32'(wr_en), 0);
        chk({tag, "_crt"}, 32'(crt_sig), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_layer"}, 32'(layer), 0);
        chk({tag, "_rd_a"}, 32'(rd_addr_a), 0);
        chk({tag, "_rd_b"}, 32'(rd_addr_b), 0);
        chk({tag, "_tw"}, 32'(tw_idx), 0);
        chk({tag, "_wr_a"}, 32'(wr_addr_a), 0);
        chk({tag, "_wr_b"}, 32'(wr_addr_b), 0);
    endtask

    // One full pass; optional fixed start-low window (by cycle offset) or random start gaps.
    task automatic drive_pass(input logic [1:0] md, input int gap_at, input int gap_len,
                              input bit rnd);
        mode     = md;
        start    = 1'b1;
        newloop  = 1'b1;
        t0       = cyc;
        first_wr = -1;
        crt_cyc  = -1;
        tick();
        newloop = 1'b0;
        for (int k = 0; k < 4000 && m_busy; k++) begin
            if (cyc >= t0 + 1 + gap_at && cyc < t0 + 1 + gap_at + gap_len) start = 1'b0;
            else if (rnd) start = ($urandom_range(0, 7) != 0);
            else start = 1'b1;
            if (rnd) newloop = ($urandom_range(0, 15) == 0);
            tick();
        end
        newloop = 1'b0;
        start   = 1'b1;
        chk("pass_end_busy", 32'(busy), 0);
    endtask

    initial begin
        int a, b, tw;
        rst = 1'b1; start = 1'b0; newloop = 1'b0; mode = MODE_NTT;
        repeat (2) @(posedge clk);
        #1;
        armed = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");
        tick();

        // Hand-derived anchors for the model's index arithmetic.
        bf_model(MODE_NTT, 0, 0, a, b, tw);
        chk("pin_ntt0_j0_a", a, 0);   chk("pin_ntt0_j0_b", b, 128); chk("pin_ntt0_j0_tw", tw, 1);
        bf_model(MODE_NTT, 0, 127, a, b, tw);
        chk("pin_ntt0_j127_a", a, 127); chk("pin_ntt0_j127_b", b, 255); chk("pin_ntt0_j127_tw", tw, 1);
        bf_model(MODE_NTT, 7, 0, a, b, tw);
        chk("pin_ntt7_j0_a", a, 0);   chk("pin_ntt7_j0_b", b, 1);   chk("pin_ntt7_j0_tw", tw, 128);
        bf_model(MODE_NTT, 7, 127, a, b, tw);
        chk("pin_ntt7_j127_a", a, 254); chk("pin_ntt7_j127_b", b, 255); chk("pin_ntt7_j127_tw", tw, 255);
        bf_model(MODE_INTT, 0, 5, a, b, tw);
        chk("pin_intt0_j5_a", a, 10); chk("pin_intt0_j5_b", b, 11); chk("pin_intt0_j5_tw", tw, 133);
        bf_model(MODE_INTT, 7, 3, a, b, tw);
        chk("pin_intt7_j3_a", a, 3);  chk("pin_intt7_j3_b", b, 131); chk("pin_intt7_j3_tw", tw, 1);

        // NTT layer 0 with exact latency checks.
        drive_pass(MODE_NTT, -100, 0, 1'b0);
        chk("ntt0_first_wr_lat", first_wr - t0, 5);
        chk("ntt0_crt_lat", crt_cyc - t0, 133);
        chk("ntt0_layer_after", 32'(layer), 1);

        for (int l = 1; l < 7; l++) drive_pass(MODE_NTT, -100, 0, 1'b1);
        chk("ntt_layer7_before", 32'(layer), 7);
        drive_pass(MODE_NTT, -100, 0, 1'b0);
        chk("ntt7_crt_lat", crt_cyc - t0, 133);
        chk("ntt_layer_wrap", 32'(layer), 0);

        // INTT: mode change restarts at layer 0.
        for (int l = 0; l < 8; l++) begin
            drive_pass(MODE_INTT, -100, 0, (l % 2) == 1);
            if (l == 0) chk("intt0_layer_after", 32'(layer), 1);
        end
        chk("intt_layer_wrap", 32'(layer), 0);

        // Sequential passes.
        drive_pass(MODE_IN, -100, 0, 1'b0);
        chk("in_first_wr_lat", first_wr - t0, 1);
        chk("in_no_crt", crt_cyc, -1);
        drive_pass(MODE_OUT, -100, 0, 1'b0);
        chk("out_no_wr", first_wr, -1);
        chk("out_no_crt", crt_cyc, -1);

        // Three-cycle start gap at j=40 pushes crt_sig out by exactly three cycles.
        drive_pass(MODE_NTT, 40, 3, 1'b0);
        chk("gap_first_wr_lat", first_wr - t0, 5);
        chk("gap_crt_lat", crt_cyc - t0, 136);

        // Reset while j=60 is issuing.
        mode = MODE_NTT; start = 1'b1; newloop = 1'b1; t0 = cyc;
        tick();
        newloop = 1'b0;
        repeat (60) tick();
        chk("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("midrst");
        tick();
        drive_pass(MODE_NTT, -100, 0, 1'b0);
        chk("post_rst_first_wr", first_wr - t0, 5);
        chk("post_rst_crt_lat", crt_cyc - t0, 133);

        // Random soak: start, newloop, mode and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            start   = ($urandom_range(0, 7) != 0);
            newloop = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0; newloop = 1'b0; start = 1'b1;
        for (int k = 0; k < 2000 && m_busy; k++) tick();
        chk("soak_end_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
